txt_ram_arbiter: RTL and testbench
==================================

TXT_RAM_ARBITER -- requirements
Module: txt_ram_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, CPU write FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter CHARS, default 1200, valid character cells (40x30).
REQ-003 SHALL have port clk  in  1  pixel clock; the block's only clock.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have port disp_req  in  1  display fetch request, one-cycle pulse.
REQ-006 SHALL have port disp_addr  in  12  display fetch cell address.
REQ-007 SHALL have port disp_data  out  8  fetched character code.
REQ-008 SHALL have port disp_valid  out  1  disp_data valid, one-cycle pulse.
REQ-009 SHALL have port cpu_wr_valid  in  1  CPU write offered.
REQ-010 SHALL have port cpu_wr_ready  out  1  CPU write accepted when high with cpu_wr_valid.
REQ-011 SHALL have port cpu_wr_addr  in  12  CPU write cell address.
REQ-012 SHALL have port cpu_wr_data  in  8  CPU write character.
REQ-013 SHALL have port wr_err  out  1  one-cycle pulse: write to an out-of-range address dropped.
REQ-014 SHALL have port clr_start  in  1  start screen clear.
REQ-015 SHALL have port clr_char  in  8  fill character, sampled at clear start.
REQ-016 SHALL have port clr_busy  out  1  clear in progress.
REQ-017 SHALL have ports ram_en, ram_we (out 1), ram_addr (out 12), ram_wdata (out 8), ram_rdata (in 8): single-port display RAM, data valid one cycle after a read.

Function
REQ-018 SHALL issue at most one RAM access per cycle; all ram_* outputs registered.
REQ-019 SHALL apply fixed priority: display read > clear write > FIFO write.
REQ-020 SHALL issue a display read in cycle N+1 for disp_req in cycle N, capture ram_rdata in N+2 and pulse disp_valid with disp_data in N+3 (latency 3, never stalled).
REQ-021 SHALL drive cpu_wr_ready = FIFO not full; push on cpu_wr_valid & cpu_wr_ready; no bypass of an empty FIFO.
REQ-022 SHALL pop one FIFO entry in any cycle with no display read and no clear write; a popped entry with address >= CHARS SHALL perform no RAM access and SHALL pulse wr_err.
REQ-023 SHALL accept a push and a pop in the same cycle when the FIFO is neither full nor empty, keeping occupancy unchanged.
REQ-024 SHALL implement clear FSM states IDLE and CLEAR; IDLE->CLEAR on clr_start (counter=0, latch clr_char); CLEAR writes counter address then increments on each non-display cycle; CLEAR->IDLE after writing CHARS-1.
REQ-025 SHALL hold clr_busy high exactly while in CLEAR; clr_start in CLEAR SHALL be ignored.
REQ-026 SHALL stall FIFO pops during CLEAR (pushes continue until full), so writes queued during a clear land after it.
REQ-027 SHALL drive ram_en=0 in idle cycles; ram_we=1 only for clear/FIFO writes.

Reset
REQ-028 SHALL, on reset low at a clk edge, set all outputs 0 except cpu_wr_ready=1, empty the FIFO, abort any clear to IDLE and cancel in-flight display reads (no disp_valid).

Configuration
REQ-029 SHALL, with TXT_CLEAR_EN defined, include the clear FSM per REQ-024..026.
REQ-030 SHALL, without TXT_CLEAR_EN, omit the FSM and counter, ignore clr_start/clr_char, and tie clr_busy to 0.

Structure
REQ-031 SHALL take TXT_COLS=40, TXT_ROWS=30, TXT_CHARS=1200, TXT_ADDR_W=12, TXT_CHAR_W=8 from shared package txt_pkg.
REQ-032 SHALL place the write FIFO in sub-module txt_wr_fifo (valid/ready push, pop strobe, full/empty).

Verification
REQ-033 SHALL verify: disp_req at addr 41 with RAM[41]=0x48 -> ram read addr 41 next cycle, disp_valid with disp_data=0x48 three cycles after request.
REQ-034 SHALL verify: 5 back-to-back CPU writes with disp_req held high -> 4 accepted, cpu_wr_ready low on the 5th, no RAM writes until disp_req drops, then writes in order.
REQ-035 SHALL verify: clr_start with clr_char=0x20 -> clr_busy for >=1200 cycles, RAM[0..1199]=0x20, display reads interleave and are never delayed.
REQ-036 SHALL verify: CPU write addr 5 data 0x41 during clear -> RAM[5]=0x41 after clr_busy falls.
REQ-037 SHALL verify: CPU write addr 1200 -> wr_err pulse, no ram_we.
REQ-038 SHALL verify: reset low mid-clear with 3 FIFO entries -> clr_busy=0, cpu_wr_ready=1, no further RAM writes.

Source files
------------

// File: rtl/txt_pkg.sv
// rtl/txt_pkg.sv - shared text-mode geometry and CPU write entry type
package txt_pkg;
    localparam int TXT_COLS   = 40;
    localparam int TXT_ROWS   = 30;
    localparam int TXT_CHARS  = 1200;
    localparam int TXT_ADDR_W = 12;
    localparam int TXT_CHAR_W = 8;

    typedef struct packed {
        logic [TXT_ADDR_W-1:0] addr;
        logic [TXT_CHAR_W-1:0] data;
    } txt_wr_t;
endpackage

// File: rtl/txt_wr_fifo.sv
// rtl/txt_wr_fifo.sv - CPU write FIFO, valid/ready push, pop strobe
// Ports: clk, reset (sync active-low); push_valid/push_ready/push_data;
//        pop (strobe, ignored when empty), pop_data (head entry); full, empty.
module txt_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit tells full from empty when the indices match.
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full       = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign empty      = (wr_ptr == rd_ptr);
    assign push_ready = !full;
    assign do_push    = push_valid && !full;
    assign do_pop     = pop && !empty;
    assign pop_data   = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
    end
endmodule

// File: rtl/txt_ram_arbiter.sv
// rtl/txt_ram_arbiter.sv - display RAM arbiter: display read > clear write > CPU FIFO write
// Ports: clk, reset (sync active-low); disp_req/disp_addr -> disp_valid/disp_data (latency 3);
//        cpu_wr_valid/cpu_wr_ready/cpu_wr_addr/cpu_wr_data, wr_err; clr_start/clr_char/clr_busy;
//        ram_en/ram_we/ram_addr/ram_wdata/ram_rdata (single-port RAM, 1-cycle read).
// Config: define TXT_CLEAR_EN to build the screen-clear FSM; otherwise clr_busy is tied 0.
module txt_ram_arbiter
    import txt_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CHARS      = TXT_CHARS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  disp_req,
    input  logic [TXT_ADDR_W-1:0] disp_addr,
    output logic [TXT_CHAR_W-1:0] disp_data,
    output logic                  disp_valid,
    input  logic                  cpu_wr_valid,
    output logic                  cpu_wr_ready,
    input  logic [TXT_ADDR_W-1:0] cpu_wr_addr,
    input  logic [TXT_CHAR_W-1:0] cpu_wr_data,
    output logic                  wr_err,
    input  logic                  clr_start,
    input  logic [TXT_CHAR_W-1:0] clr_char,
    output logic                  clr_busy,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [TXT_ADDR_W-1:0] ram_addr,
    output logic [TXT_CHAR_W-1:0] ram_wdata,
    input  logic [TXT_CHAR_W-1:0] ram_rdata
);
    localparam logic [TXT_ADDR_W-1:0] LAST_CELL = TXT_ADDR_W'(CHARS - 1);

    txt_wr_t               push_word;
    txt_wr_t               fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  clr_active;
    logic                  clr_wr;
    logic [TXT_ADDR_W-1:0] clr_cnt;
    logic [TXT_CHAR_W-1:0] clr_fill;
    logic [1:0]            rd_pipe;

    assign push_word = '{addr: cpu_wr_addr, data: cpu_wr_data};
    // A clear owns every non-display cycle, so the FIFO drains only outside CLEAR.
    assign fifo_pop  = !disp_req && !clr_active;

    txt_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(txt_wr_t))
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_valid (cpu_wr_valid),
        .push_ready (cpu_wr_ready),
        .push_data  (push_word),
        .pop        (fifo_pop),
        .pop_data   (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

`ifdef TXT_CLEAR_EN
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0] state;

    assign clr_active = (state == ST_CLEAR);
    assign clr_wr     = clr_active && !disp_req;
    assign clr_busy   = clr_active;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            clr_cnt  <= '0;
            clr_fill <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_start) begin
                        state    <= ST_CLEAR;
                        clr_cnt  <= '0;
                        clr_fill <= clr_char;
                    end
                end
                default: begin
                    if (clr_wr) begin
                        if (clr_cnt == LAST_CELL) state <= ST_IDLE;
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
`else
    logic unused_clr;

    assign unused_clr = ^{clr_start, clr_char};
    assign clr_active = 1'b0;
    assign clr_wr     = 1'b0;
    assign clr_busy   = 1'b0;
    assign clr_cnt    = '0;
    assign clr_fill   = '0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            rd_pipe    <= '0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
            wr_err     <= 1'b0;
        end else begin
            // rd_pipe[0]: read on the RAM port, rd_pipe[1]: ram_rdata valid now.
            rd_pipe    <= {rd_pipe[0], disp_req};
            disp_valid <= rd_pipe[1];
            if (rd_pipe[1]) disp_data <= ram_rdata;

            ram_en <= 1'b0;
            ram_we <= 1'b0;
            wr_err <= 1'b0;
            if (disp_req) begin
                ram_en    <= 1'b1;
                ram_addr  <= disp_addr;
                ram_wdata <= '0;
            end else if (clr_wr) begin
                ram_en    <= 1'b1;
                ram_we    <= 1'b1;
                ram_addr  <= clr_cnt;
                ram_wdata <= clr_fill;
            end else if (!fifo_empty) begin
                if (fifo_head.addr <= LAST_CELL) begin
                    ram_en    <= 1'b1;
                    ram_we    <= 1'b1;
                    ram_addr  <= fifo_head.addr;
                    ram_wdata <= fifo_head.data;
                end else begin
                    wr_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_txt_ram_arbiter.sv
// tb/tb_txt_ram_arbiter.sv - directed self-checking bench for txt_ram_arbiter
module tb_txt_ram_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        disp_req = 1'b0;
    logic [11:0] disp_addr = '0;
    logic [7:0]  disp_data;
    logic        disp_valid;
    logic        cpu_wr_valid = 1'b0;
    logic        cpu_wr_ready;
    logic [11:0] cpu_wr_addr = '0;
    logic [7:0]  cpu_wr_data = '0;
    logic        wr_err;
    logic        clr_start = 1'b0;
    logic [7:0]  clr_char = '0;
    logic        clr_busy;
    logic        ram_en;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    logic [7:0]  mem [0:4095];
    logic [19:0] wlog [$];

    int total = 0;
    int bad   = 0;

    txt_ram_arbiter #(.FIFO_DEPTH(4), .CHARS(1200)) dut (
        .clk          (clk),
        .reset        (reset),
        .disp_req     (disp_req),
        .disp_addr    (disp_addr),
        .disp_data    (disp_data),
        .disp_valid   (disp_valid),
        .cpu_wr_valid (cpu_wr_valid),
        .cpu_wr_ready (cpu_wr_ready),
        .cpu_wr_addr  (cpu_wr_addr),
        .cpu_wr_data  (cpu_wr_data),
        .wr_err       (wr_err),
        .clr_start    (clr_start),
        .clr_char     (clr_char),
        .clr_busy     (clr_busy),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                wlog.push_back({ram_addr, ram_wdata});
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [11:0] a, input logic [7:0] d);
        cpu_wr_valid = 1'b1;
        cpu_wr_addr  = a;
        cpu_wr_data  = d;
        for (int i = 0; i < 50 && !cpu_wr_ready; i++) step();
        chk("cpu_wr_ready", 32'(cpu_wr_ready), 32'd1);
        step();
        cpu_wr_valid = 1'b0;
    endtask

    initial begin
        int          base;
        int          errs;
        int          vcnt;
        logic [19:0] e;

        step(3);
        chk("rst_disp_valid", 32'(disp_valid), 0);
        chk("rst_disp_data", 32'(disp_data), 0);
        chk("rst_wr_err", 32'(wr_err), 0);
        chk("rst_clr_busy", 32'(clr_busy), 0);
        chk("rst_cpu_wr_ready", 32'(cpu_wr_ready), 1);
        chk("rst_ram_en", 32'(ram_en), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_ram_wdata", 32'(ram_wdata), 0);
        reset = 1'b1;
        step();

        // Display read of cell 41 holding 0x48
        cpu_write(12'd41, 8'h48);
        step(4);
        chk("preload41", 32'(mem[41]), 32'h48);
        disp_req  = 1'b1;
        disp_addr = 12'd41;
        step();
        chk("rd_cmd", {18'd0, ram_en, ram_we, ram_addr}, {18'd0, 1'b1, 1'b0, 12'd41});
        disp_req = 1'b0;
        step();
        chk("rd_valid_n2", 32'(disp_valid), 0);
        step();
        chk("rd_valid_n3", 32'(disp_valid), 1);
        chk("rd_data_n3", 32'(disp_data), 32'h48);
        step();
        chk("rd_valid_n4", 32'(disp_valid), 0);

        // Five writes under continuous display reads: FIFO fills at four
        base     = wlog.size();
        disp_req = 1'b1;
        disp_addr = 12'd0;
        for (int i = 0; i < 5; i++) begin
            cpu_wr_valid = 1'b1;
            cpu_wr_addr  = 12'(100 + i);
            cpu_wr_data  = 8'(8'h60 + i);
            chk($sformatf("full_ready%0d", i), 32'(cpu_wr_ready), (i < 4) ? 32'd1 : 32'd0);
            step();
        end
        cpu_wr_valid = 1'b0;
        step(2);
        chk("no_wr_during_disp", 32'(wlog.size() - base), 0);
        disp_req = 1'b0;
        step(8);
        chk("wr_count_after", 32'(wlog.size() - base), 4);
        for (int i = 0; i < 4; i++) begin
            e = {12'(100 + i), 8'(8'h60 + i)};
            chk($sformatf("wr_order%0d", i), (wlog.size() > base + i) ? 32'(wlog[base + i]) : 32'hdead, 32'(e));
        end
        chk("ready_after_drain", 32'(cpu_wr_ready), 1);

        // Out-of-range write is dropped with wr_err; last valid cell is written
        base = wlog.size();
        errs = 0;
        cpu_write(12'd1200, 8'h77);
        for (int i = 0; i < 10; i++) begin
            if (wr_err) errs++;
            step();
        end
        chk("oor_wr_err", 32'(errs), 1);
        chk("oor_no_we", 32'(wlog.size() - base), 0);
        errs = 0;
        cpu_write(12'd1199, 8'h55);
        for (int i = 0; i < 8; i++) begin
            if (wr_err) errs++;
            step();
        end
        chk("last_cell_no_err", 32'(errs), 0);
        chk("last_cell_we", 32'(wlog.size() - base), 1);
        chk("last_cell_data", (wlog.size() > base) ? 32'(wlog[base]) : 32'hdead, 32'({12'd1199, 8'h55}));

        // Reset cancels an in-flight display read
        disp_req  = 1'b1;
        disp_addr = 12'd41;
        step();
        disp_req = 1'b0;
        reset    = 1'b0;
        step();
        chk("rst_cancel_ram_en", 32'(ram_en), 0);
        reset = 1'b1;
        vcnt  = 0;
        for (int i = 0; i < 5; i++) begin
            if (disp_valid) vcnt++;
            step();
        end
        chk("rst_cancel_no_valid", 32'(vcnt), 0);

`ifdef TXT_CLEAR_EN
        begin
            int cyc;
            int badcells;
            clr_char  = 8'h20;
            clr_start = 1'b1;
            step();
            clr_start = 1'b0;
            chk("clr_busy_start", 32'(clr_busy), 1);
            cyc = 0;
            while (clr_busy && cyc < 3000) begin
                disp_req     = (cyc % 16 == 3);
                disp_addr    = 12'(cyc % 1200);
                cpu_wr_valid = (cyc == 10);
                cpu_wr_addr  = 12'd5;
                cpu_wr_data  = 8'h41;
                clr_start    = (cyc == 50);
                clr_char     = (cyc == 50) ? 8'h99 : 8'h20;
                step();
                if (disp_req)
                    chk("clr_rd_cmd", {18'd0, ram_en, ram_we, ram_addr}, {18'd0, 1'b1, 1'b0, disp_addr});
                cyc++;
            end
            disp_req     = 1'b0;
            cpu_wr_valid = 1'b0;
            clr_start    = 1'b0;
            chk("clr_no_timeout", 32'(cyc < 3000), 1);
            chk("clr_busy_len", 32'(cyc >= 1200), 1);
            step(10);
            chk("clr_cpu_wr_after", 32'(mem[5]), 32'h41);
            badcells = 0;
            for (int a = 0; a < 1200; a++)
                if (a != 5 && mem[a] !== 8'h20) badcells++;
            chk("clr_fill_cells", 32'(badcells), 0);

            clr_char  = 8'h20;
            clr_start = 1'b1;
            step();
            clr_start = 1'b0;
            step(20);
            for (int i = 0; i < 3; i++) begin
                cpu_wr_valid = 1'b1;
                cpu_wr_addr  = 12'(200 + i);
                cpu_wr_data  = 8'(i);
                step();
            end
            cpu_wr_valid = 1'b0;
            chk("mid_clr_busy", 32'(clr_busy), 1);
            chk("mid_clr_ready", 32'(cpu_wr_ready), 1);
            reset = 1'b0;
            step();
            chk("rst_clr_busy_low", 32'(clr_busy), 0);
            chk("rst_clr_ready", 32'(cpu_wr_ready), 1);
            reset = 1'b1;
            base  = wlog.size();
            step(20);
            chk("rst_clr_no_writes", 32'(wlog.size() - base), 0);
        end
`else
        base      = wlog.size();
        clr_char  = 8'h20;
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        chk("noclr_busy0", 32'(clr_busy), 0);
        step(5);
        chk("noclr_busy1", 32'(clr_busy), 0);
        chk("noclr_no_writes", 32'(wlog.size() - base), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
